// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state encoding and instruction-field helpers for the accumulator core.
package acc_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h5;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h6;
    localparam logic [OPC_W-1:0] OP_OUT   = 4'h7;
    localparam logic [OPC_W-1:0] OP_LDI   = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'h9;
    localparam logic [OPC_W-1:0] OP_JZ    = 4'hA;
    localparam logic [OPC_W-1:0] OP_JC    = 4'hB;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // The opcode sits directly above the operand field.
    function automatic int opc_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int instr_w(input int addr_w);
        return addr_w + OPC_W;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator core: result, carry/borrow and zero for the ACC-writing ops.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit of the difference is the borrow (acc < m).
    assign sum  = {1'b0, acc} + {1'b0, m};
    assign diff = {1'b0, acc} - {1'b0, m};

    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode)
            OP_LOAD, OP_LDI: result = m;
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND:  result = acc & m;
            OP_OR:   result = acc | m;
            default: result = acc;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core with fetch/decode/execute FSM and host-loaded data RAM.
// Optional single-step control is enabled by defining ACC_CPU_CORE_STEP_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start; host may write data RAM
// FETCH  | imem_addr = PC presented to program memory
// DECODE | IR captured from imem_rdata, PC incremented
// EXEC   | instruction executed
// HALTED | HALT retired; outputs held, host may write data RAM
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
`ifdef ACC_CPU_CORE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_W-1:0]     imem_addr,
    input  logic [3+ADDR_W:0]   imem_rdata,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_waddr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   ACC_OUT,
    output logic [DATA_W-1:0]   OUT_PORT,
    output logic                out_valid,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);

    localparam int IW = instr_w(ADDR_W);
    localparam int OL = opc_lsb(ADDR_W);

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] acc;

    logic [DATA_W-1:0] dmem [2**ADDR_W];

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] op;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] alu_m;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic [PC_W-1:0]   jump_tgt;
    logic              idle_like;
    logic              fetch_go;
    logic              host_we;
    logic              store_we;

    assign opcode    = ir[OL +: OPC_W];
    assign op        = ir[ADDR_W-1:0];
    assign mem_rd    = dmem[op];
    assign alu_m     = (opcode == OP_LDI) ? DATA_W'(op) : mem_rd;
    assign jump_tgt  = PC_W'(op);
    assign idle_like = (state == S_IDLE) || (state == S_HALTED);
    assign imem_addr = pc;

`ifdef ACC_CPU_CORE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Gating on RST_N keeps a reset that lands mid-EXEC from completing a STORE.
    assign host_we  = RST_N && dm_we && idle_like;
    assign store_we = RST_N && (state == S_EXEC) && (opcode == OP_STORE);

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (opcode),
        .acc    (acc),
        .m      (alu_m),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge CLK) begin
        if (host_we)
            dmem[dm_waddr] <= dm_wdata;
        else if (store_we)
            dmem[op] <= acc;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            ACC_OUT   <= '0;
            OUT_PORT  <= '0;
            out_valid <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            ACC_OUT   <= acc;
            out_valid <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_go)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    ir    <= imem_rdata;
                    pc    <= pc + PC_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: begin
                            acc    <= alu_result;
                            flag_z <= alu_zero;
                            if ((opcode == OP_ADD) || (opcode == OP_SUB))
                                flag_c <= alu_carry;
                        end
                        OP_OUT: begin
                            OUT_PORT  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_JMP: pc <= jump_tgt;
                        OP_JZ: begin
                            if (flag_z)
                                pc <= jump_tgt;
                        end
                        OP_JC: begin
                            if (flag_c)
                                pc <= jump_tgt;
                        end
                        OP_HALT: begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
